// File: rtl/seq_pattern_gen_pkg.sv
// seq_pattern_gen shared types and defaults.
// FSM state encoding and parameter defaults.
package seq_gen_pkg;

  localparam int MAX_LEN_DEF = 16;
  localparam int CNT_W_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/seq_pattern_gen_if.sv
// Control/serial bundle of seq_pattern_gen.
// master = requester, slave = generator.
interface seq_pattern_gen_if
  import seq_gen_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1,
  parameter int CNT_W   = CNT_W_DEF
);

  logic               start;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic [CNT_W-1:0]   reps;
  logic [CNT_W-1:0]   gap;
  logic               stop;
  logic               out;
  logic               valid;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output start, pattern, len, reps, gap, stop,
    input  out, valid, busy, done, err
  );

  modport slave (
    input  start, pattern, len, reps, gap, stop,
    output out, valid, busy, done, err
  );

endinterface

// File: rtl/seq_pattern_gen_counter.sv
// Loadable down-counter with zero flag.
// Holds at zero; load has priority over dec.
module seq_gen_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] din,
  output logic [W-1:0] q,
  output logic         zero
);

  assign zero = (q == '0);

  // load, or count down until zero
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (dec && !zero) begin
      q <= q - W'(1);
    end
  end

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial MSB-first pattern generator with
// repeat count and idle-zero gap.
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1,
  parameter int CNT_W   = CNT_W_DEF
) (
  input logic          clk,
  input logic          resetn,
  seq_pattern_gen_if.slave bus
);

  state_t             state_q;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [CNT_W-1:0]   gap_q;
  logic               out_q;
  logic               valid_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;

  logic [LEN_W-1:0]   idx_q;
  logic               idx_zero;
  logic [CNT_W-1:0]   rep_q;
  logic               rep_zero;
  logic [CNT_W-1:0]   gap_cnt;
  logic               gap_zero;

  logic               len_ok;
  logic               accept;
  logic               more;
  logic               last;
  logic               gap_end;
  logic               restart;
  logic               idx_ld;
  logic               idx_dec;
  logic [LEN_W-1:0]   idx_din;
  logic               rep_ld;
  logic               rep_dec;
  logic               gap_ld;
  logic               gap_dec;
  logic [CNT_W-1:0]   gap_din;

  function automatic logic bit_at(
    input logic [MAX_LEN-1:0] p,
    input logic [LEN_W-1:0]   i
  );
    return |(p & (MAX_LEN'(1) << i));
  endfunction

  assign len_ok = (bus.len != '0) &&
                  (bus.len <= LEN_W'(MAX_LEN));
  assign accept = (state_q == IDLE) &&
                  bus.start && len_ok;

  // rep counter == 0 marks continuous mode
  assign more = rep_zero ||
                (rep_q != CNT_W'(1));

  assign last = (state_q == SHIFT) &&
                !bus.stop && idx_zero;

  assign gap_end = (state_q == GAP) &&
                   !bus.stop &&
                   (gap_cnt == CNT_W'(1));

  // next repetition begins on this edge
  assign restart = (last && more && gap_zero) ||
                   gap_end;

  assign idx_ld  = accept || restart;
  assign idx_dec = (state_q == SHIFT) &&
                   !bus.stop && !idx_zero;
  assign idx_din = (state_q == IDLE)
                 ? bus.len - LEN_W'(1)
                 : len_q - LEN_W'(1);

  assign rep_ld  = accept;
  assign rep_dec = last && more && !rep_zero;

  assign gap_ld  = accept || restart;
  assign gap_dec = (state_q == GAP) &&
                   !bus.stop &&
                   (gap_cnt != CNT_W'(1));
  assign gap_din = (state_q == IDLE)
                 ? bus.gap : gap_q;

  seq_gen_counter #(.W(LEN_W)) u_idx (
    .clk    (clk),
    .resetn (resetn),
    .load   (idx_ld),
    .dec    (idx_dec),
    .din    (idx_din),
    .q      (idx_q),
    .zero   (idx_zero)
  );

  seq_gen_counter #(.W(CNT_W)) u_rep (
    .clk    (clk),
    .resetn (resetn),
    .load   (rep_ld),
    .dec    (rep_dec),
    .din    (bus.reps),
    .q      (rep_q),
    .zero   (rep_zero)
  );

  seq_gen_counter #(.W(CNT_W)) u_gap (
    .clk    (clk),
    .resetn (resetn),
    .load   (gap_ld),
    .dec    (gap_dec),
    .din    (gap_din),
    .q      (gap_cnt),
    .zero   (gap_zero)
  );

  // FSM, captured operands and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      gap_q   <= '0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            pat_q   <= bus.pattern;
            len_q   <= bus.len;
            gap_q   <= bus.gap;
            state_q <= SHIFT;
            out_q   <= bit_at(bus.pattern,
                              bus.len - LEN_W'(1));
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end else if (bus.start) begin
            err_q <= 1'b1;
          end
        end
        SHIFT: begin
          if (bus.stop) begin
            state_q <= IDLE;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (!idx_zero) begin
            out_q <= bit_at(pat_q,
                            idx_q - LEN_W'(1));
          end else if (more && !gap_zero) begin
            state_q <= GAP;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
          end else if (more) begin
            out_q <= bit_at(pat_q,
                            len_q - LEN_W'(1));
          end else begin
            state_q <= IDLE;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        GAP: begin
          if (bus.stop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (gap_end) begin
            state_q <= SHIFT;
            out_q   <= bit_at(pat_q,
                              len_q - LEN_W'(1));
            valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.out   = out_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: queue-based
// reference model plus directed scenarios.
module tb_seq_pattern_gen;

  localparam int ML = 16;
  localparam int LW = $clog2(ML) + 1;
  localparam int CW = 8;

  logic clk;
  logic resetn;

  seq_pattern_gen_if #(
    .MAX_LEN(ML), .LEN_W(LW), .CNT_W(CW)
  ) sif ();

  seq_pattern_gen #(
    .MAX_LEN(ML), .LEN_W(LW), .CNT_W(CW)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec;
  int miss;

  // model: queue of future {valid,out} cycles
  logic [1:0]  mq[$];
  logic        m_out, m_valid, m_busy;
  logic        m_done, m_err, m_cont;
  logic [ML-1:0] m_pat;
  int          m_len, m_gap;

  // observation stats
  logic [63:0] sbuf;
  int nbusy, nvalid, ndone, nerr;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic push_rep();
    for (int i = m_len - 1; i >= 0; i--)
      mq.push_back({1'b1, m_pat[i]});
  endtask

  task automatic push_gap();
    for (int i = 0; i < m_gap; i++)
      mq.push_back(2'b00);
  endtask

  task automatic pop();
    logic [1:0] e;
    e = mq.pop_front();
    m_valid = e[1];
    m_out   = e[0];
  endtask

  task automatic model_reset();
    mq.delete();
    m_out = 0; m_valid = 0; m_busy = 0;
    m_done = 0; m_err = 0; m_cont = 0;
  endtask

  // advance model across one clock edge
  task automatic model_next();
    int n;
    m_done = 0;
    m_err  = 0;
    if (!m_busy) begin
      m_out = 0;
      m_valid = 0;
      if (sif.start) begin
        n = int'(sif.len);
        if (n >= 1 && n <= ML) begin
          m_pat  = sif.pattern;
          m_len  = n;
          m_gap  = int'(sif.gap);
          m_cont = (sif.reps == 0);
          mq.delete();
          if (m_cont) push_rep();
          else
            for (int r = 0; r < int'(sif.reps); r++) begin
              if (r > 0) push_gap();
              push_rep();
            end
          pop();
          m_busy = 1;
        end else begin
          m_err = 1;
        end
      end
    end else if (sif.stop) begin
      mq.delete();
      m_busy = 0; m_out = 0; m_valid = 0;
    end else if (mq.size() == 0) begin
      if (m_cont) begin
        push_gap();
        push_rep();
        pop();
      end else begin
        m_busy = 0; m_out = 0; m_valid = 0;
        m_done = 1;
      end
    end else begin
      pop();
    end
  endtask

  // one clock: model, edge, compare, record
  task automatic step();
    model_next();
    @(posedge clk);
    #1;
    chk("out",   64'(sif.out),   64'(m_out));
    chk("valid", 64'(sif.valid), 64'(m_valid));
    chk("busy",  64'(sif.busy),  64'(m_busy));
    chk("done",  64'(sif.done),  64'(m_done));
    chk("err",   64'(sif.err),   64'(m_err));
    if (sif.busy) begin
      sbuf = {sbuf[62:0], sif.out};
      nbusy++;
    end
    if (sif.valid) nvalid++;
    if (sif.done) ndone++;
    if (sif.err) nerr++;
  endtask

  task automatic clr_stats();
    sbuf = '0;
    nbusy = 0; nvalid = 0; ndone = 0; nerr = 0;
  endtask

  task automatic go(input logic [ML-1:0] p,
                    input int l, input int r,
                    input int g);
    sif.pattern = p;
    sif.len     = LW'(l);
    sif.reps    = CW'(r);
    sif.gap     = CW'(g);
    sif.start   = 1'b1;
    step();
    sif.start   = 1'b0;
  endtask

  function automatic int cnt1001(
    input logic [63:0] s, input int n);
    int c;
    c = 0;
    for (int i = 0; i + 3 < n; i++)
      if (s[i+3 -: 4] == 4'b1001) c++;
    return c;
  endfunction

  initial begin
    vec = 0; miss = 0;
    resetn = 1'b0;
    sif.start = 0; sif.stop = 0;
    sif.pattern = '0; sif.len = '0;
    sif.reps = '0; sif.gap = '0;
    model_reset();
    clr_stats();
    #2;
    chk("rst_out",   64'(sif.out),   0);
    chk("rst_valid", 64'(sif.valid), 0);
    chk("rst_busy",  64'(sif.busy),  0);
    chk("rst_done",  64'(sif.done),  0);
    chk("rst_err",   64'(sif.err),   0);
    #10 resetn = 1'b1;
    step();

    // single 1001
    clr_stats();
    go(16'b1001, 4, 1, 0);
    repeat (5) step();
    chk("s1_stream", sbuf[3:0], 4'b1001);
    chk("s1_busy", 64'(nbusy), 4);
    chk("s1_valid", 64'(nvalid), 4);
    chk("s1_done", 64'(ndone), 1);
    chk("s1_det", 64'(cnt1001(sbuf, 4)), 1);

    // two reps, gap 2
    clr_stats();
    go(16'b1001, 4, 2, 2);
    repeat (12) step();
    chk("s2_stream", sbuf[9:0], 10'b1001001001);
    chk("s2_busy", 64'(nbusy), 10);
    chk("s2_valid", 64'(nvalid), 8);
    chk("s2_done", 64'(ndone), 1);

    // rejected lengths
    clr_stats();
    go(16'hffff, 0, 1, 0);
    step();
    go(16'hffff, ML + 1, 1, 0);
    step();
    chk("s3_err", 64'(nerr), 2);
    chk("s3_busy", 64'(nbusy), 0);

    // continuous, stop after 9 bits
    clr_stats();
    go(16'b1001, 4, 0, 0);
    repeat (8) step();
    sif.stop = 1'b1;
    step();
    sif.stop = 1'b0;
    chk("s4_out_after", 64'(sif.out), 0);
    repeat (3) step();
    chk("s4_stream", sbuf[8:0], 9'b100110011);
    chk("s4_busy", 64'(nbusy), 9);
    chk("s4_done", 64'(ndone), 0);
    chk("s4_det", 64'(cnt1001(sbuf, 9)), 2);

    // async reset mid-shift
    go(16'b1001, 4, 1, 0);
    step();
    chk("s5_pre_valid", 64'(sif.valid), 1);
    #3 resetn = 1'b0;
    #1;
    chk("s5_out",   64'(sif.out),   0);
    chk("s5_valid", 64'(sif.valid), 0);
    chk("s5_busy",  64'(sif.busy),  0);
    model_reset();
    #3 resetn = 1'b1;
    step();
    clr_stats();
    go(16'b1001, 4, 1, 0);
    repeat (5) step();
    chk("s5_stream", sbuf[3:0], 4'b1001);
    chk("s5_done", 64'(ndone), 1);

    // start during done, ignored start mid-shift
    go(16'b1001, 4, 1, 0);
    repeat (4) step();
    chk("s6_done_cyc", 64'(sif.done), 1);
    clr_stats();
    go(16'b110, 3, 1, 0);
    chk("s6_first", 64'(sif.out), 1);
    chk("s6_first_v", 64'(sif.valid), 1);
    go(16'h0, 0, 1, 0);
    chk("s6_no_err", 64'(sif.err), 0);
    repeat (3) step();
    chk("s6_stream", sbuf[2:0], 3'b110);
    chk("s6_nerr", 64'(nerr), 0);

    // random traffic; inputs churn while busy
    for (int c = 0; c < 3000; c++) begin
      sif.start   = ($urandom_range(0, 3) == 0);
      sif.stop    = ($urandom_range(0, 24) == 0);
      sif.pattern = ML'($urandom);
      sif.len     = LW'($urandom_range(0, ML + 1));
      sif.reps    = CW'($urandom_range(0, 3));
      sif.gap     = CW'($urandom_range(0, 3));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, miss);
    $finish;
  end

endmodule
